// File: rtl/control_seq_pkg.sv
// Shared types and widths for the control loop sequencer slice.
package control_seq_pkg;

    localparam int unsigned ADC_WIDTH     = 12;
    localparam int unsigned PARAM_WIDTH   = 8;
    localparam int unsigned OVERRUN_WIDTH = 8;

    localparam logic ADDR_P        = 1'b0;
    localparam logic ADDR_SETPOINT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        WAIT_ADC,
        COMMIT,
        WAIT_TICK,
        FAULT
    } seq_state_e;

endpackage

// File: rtl/control_loop_sequencer_if.sv
// Parameter-write, ADC handshake and controller-facing signals of the sequencer.
interface control_loop_sequencer_if;
    import control_seq_pkg::*;

    logic                     param_write_valid;
    logic                     param_write_address;
    logic [PARAM_WIDTH-1:0]   param_write_value;
    logic                     adc_start;
    logic [ADC_WIDTH-1:0]     adc_reading;
    logic                     adc_reading_valid;
    logic [ADC_WIDTH-1:0]     sensor_reading;
    logic [PARAM_WIDTH-1:0]   p;
    logic [PARAM_WIDTH-1:0]   setpoint;
    logic                     update;
    logic                     motor_enable;
    logic                     fault;
    logic [OVERRUN_WIDTH-1:0] overrun_count;

    modport master (
        input  param_write_valid, param_write_address, param_write_value,
        input  adc_reading, adc_reading_valid,
        output adc_start, sensor_reading, p, setpoint, update,
        output motor_enable, fault, overrun_count
    );

    modport slave (
        output param_write_valid, param_write_address, param_write_value,
        output adc_reading, adc_reading_valid,
        input  adc_start, sensor_reading, p, setpoint, update,
        input  motor_enable, fault, overrun_count
    );

endinterface

// File: rtl/loop_timer.sv
// Free-running period counter; tick_c marks the last cycle of each period.
module loop_timer #(
    parameter int unsigned PERIOD = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick_c
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + CNT_W'(1);
        end
    end

    assign tick_c = run && (count == LAST);

endmodule

// File: rtl/control_loop_sequencer.sv
// Fixed-rate control loop sequencer: ADC trigger with timeout, atomic
// parameter commit, controller strobe and fault-aware motor enable.
module control_loop_sequencer
    import control_seq_pkg::*;
#(
    parameter int unsigned LOOP_PERIOD = 50000,
    parameter int unsigned ADC_TIMEOUT = 2000,
    parameter int unsigned MAX_FAULTS  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    control_loop_sequencer_if.master bus
);

    localparam int unsigned TO_W  = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
    localparam int unsigned FLT_W = $clog2(MAX_FAULTS + 1);

    seq_state_e               state, state_d;
    logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
    logic [FLT_W-1:0]         flt_cnt_q, flt_cnt_d, flt_inc;
    logic [PARAM_WIDTH-1:0]   pend_p_q, pend_p_d, pend_sp_q, pend_sp_d;
    logic [PARAM_WIDTH-1:0]   p_q, p_d, sp_q, sp_d;
    logic [ADC_WIDTH-1:0]     sensor_q, sensor_d;
    logic [OVERRUN_WIDTH-1:0] ovr_q, ovr_d;
    logic                     adc_start_q, adc_start_d;
    logic                     update_q, update_d;
    logic                     motor_en_q, motor_en_d;
    logic                     fault_q, fault_d;
    logic                     running, tick_c;

    assign running = (state == SAMPLE) || (state == WAIT_ADC) ||
                     (state == COMMIT) || (state == WAIT_TICK);
    assign flt_inc = flt_cnt_q + FLT_W'(1);

    loop_timer #(.PERIOD(LOOP_PERIOD)) u_loop_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!running),
        .run    (running),
        .tick_c (tick_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        to_cnt_d    = to_cnt_q;
        flt_cnt_d   = flt_cnt_q;
        pend_p_d    = pend_p_q;
        pend_sp_d   = pend_sp_q;
        p_d         = p_q;
        sp_d        = sp_q;
        sensor_d    = sensor_q;
        ovr_d       = ovr_q;
        update_d    = 1'b0;
        motor_en_d  = motor_en_q;
        fault_d     = fault_q;

        if (bus.param_write_valid) begin
            if (bus.param_write_address == ADDR_P) begin
                pend_p_d = bus.param_write_value;
            end else if (bus.param_write_address == ADDR_SETPOINT) begin
                pend_sp_d = bus.param_write_value;
            end
        end

        // A tick outside WAIT_TICK means the iteration ran long; it is dropped.
        if (tick_c && (state != WAIT_TICK) && (ovr_q != '1)) begin
            ovr_d = ovr_q + OVERRUN_WIDTH'(1);
        end

        if (running && !enable) begin
            state_d    = IDLE;
            motor_en_d = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) state_d = SAMPLE;
                end
                SAMPLE: begin
                    to_cnt_d = '0;
                    state_d  = WAIT_ADC;
                end
                WAIT_ADC: begin
                    if (bus.adc_reading_valid) begin
                        sensor_d  = bus.adc_reading;
                        flt_cnt_d = '0;
                        state_d   = COMMIT;
                    end else if (to_cnt_q == TO_W'(ADC_TIMEOUT - 1)) begin
                        flt_cnt_d = flt_inc;
                        if (flt_inc == FLT_W'(MAX_FAULTS)) begin
                            state_d    = FAULT;
                            fault_d    = 1'b1;
                            motor_en_d = 1'b0;
                        end else begin
                            state_d = WAIT_TICK;
                        end
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                COMMIT: begin
                    p_d        = pend_p_q;
                    sp_d       = pend_sp_q;
                    update_d   = 1'b1;
                    motor_en_d = 1'b1;
                    state_d    = WAIT_TICK;
                end
                WAIT_TICK: begin
                    if (tick_c) state_d = SAMPLE;
                end
                FAULT: begin
                    fault_d    = 1'b1;
                    motor_en_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end

        adc_start_d = (state_d == SAMPLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            to_cnt_q    <= '0;
            flt_cnt_q   <= '0;
            pend_p_q    <= '0;
            pend_sp_q   <= '0;
            p_q         <= '0;
            sp_q        <= '0;
            sensor_q    <= '0;
            ovr_q       <= '0;
            adc_start_q <= 1'b0;
            update_q    <= 1'b0;
            motor_en_q  <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state       <= state_d;
            to_cnt_q    <= to_cnt_d;
            flt_cnt_q   <= flt_cnt_d;
            pend_p_q    <= pend_p_d;
            pend_sp_q   <= pend_sp_d;
            p_q         <= p_d;
            sp_q        <= sp_d;
            sensor_q    <= sensor_d;
            ovr_q       <= ovr_d;
            adc_start_q <= adc_start_d;
            update_q    <= update_d;
            motor_en_q  <= motor_en_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.adc_start      = adc_start_q;
    assign bus.sensor_reading = sensor_q;
    assign bus.p              = p_q;
    assign bus.setpoint       = sp_q;
    assign bus.update         = update_q;
    assign bus.motor_enable   = motor_en_q;
    assign bus.fault          = fault_q;
    assign bus.overrun_count  = ovr_q;

endmodule

// File: tb/tb_control_loop_sequencer.sv
// Scoreboard bench for control_loop_sequencer: directed loop, parameter,
// timeout/fault, enable-drop and overrun scenarios.
module tb_control_loop_sequencer;
    import control_seq_pkg::*;

    localparam int unsigned PERIOD  = 100;
    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned FAULTS  = 3;
    localparam int EV_START  = 0;
    localparam int EV_UPDATE = 1;

    typedef struct {
        int          kind;
        int          cyc;
        logic [11:0] sensor;
        logic [7:0]  p;
        logic [7:0]  sp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, reset2, enable, enable2;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    int          adc_plan[$];
    logic [11:0] adc_value = 12'hABC;

    control_loop_sequencer_if bus();
    control_loop_sequencer_if bus2();

    control_loop_sequencer #(
        .LOOP_PERIOD(PERIOD), .ADC_TIMEOUT(TIMEOUT), .MAX_FAULTS(FAULTS)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus.master)
    );

    // Second instance with a long timeout so a 150-cycle ADC overruns the period.
    control_loop_sequencer #(
        .LOOP_PERIOD(PERIOD), .ADC_TIMEOUT(200), .MAX_FAULTS(FAULTS)
    ) dut_ovr (
        .clk(clk), .reset(reset2), .enable(enable2), .bus(bus2.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic void exp_start(input int c);
        exp_t e;
        e.kind = EV_START; e.cyc = c; e.sensor = '0; e.p = '0; e.sp = '0;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_update(input int c, input logic [11:0] s,
                                       input logic [7:0] p, input logic [7:0] sp);
        exp_t e;
        e.kind = EV_UPDATE; e.cyc = c; e.sensor = s; e.p = p; e.sp = sp;
        exp_q.push_back(e);
    endfunction

    task automatic write_param(input logic addr, input logic [7:0] val);
        bus.param_write_address = addr;
        bus.param_write_value   = val;
        bus.param_write_valid   = 1'b1;
        @(negedge clk);
        bus.param_write_valid   = 1'b0;
    endtask

    task automatic observe(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_%s at cycle %0d: got event, expected none",
                     (kind == EV_START) ? "adc_start" : "update", cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            chk((kind == EV_START) ? "start_cycle" : "update_cycle", 32'(cyc), 32'(e.cyc));
            if (kind == EV_UPDATE) begin
                chk("sensor_reading", 32'(bus.sensor_reading), 32'(e.sensor));
                chk("p", 32'(bus.p), 32'(e.p));
                chk("setpoint", 32'(bus.setpoint), 32'(e.sp));
                chk("motor_enable_at_update", 32'(bus.motor_enable), 32'd1);
            end
        end
    endtask

    // Monitor: every adc_start/update pulse consumes one expected event.
    always @(negedge clk) begin
        if (bus.adc_start === 1'b1) observe(EV_START);
        if (bus.update === 1'b1)    observe(EV_UPDATE);
    end

    // ADC model for the main instance; plan entry -1 means no response.
    initial begin
        bus.adc_reading       = '0;
        bus.adc_reading_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.adc_start === 1'b1) begin
                int lat;
                lat = (adc_plan.size() > 0) ? adc_plan.pop_front() : 10;
                if (lat >= 0) begin
                    repeat (lat) @(negedge clk);
                    bus.adc_reading       = adc_value;
                    bus.adc_reading_valid = 1'b1;
                    @(negedge clk);
                    bus.adc_reading_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        bus2.adc_reading       = 12'h5A5;
        bus2.adc_reading_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (bus2.adc_start === 1'b1) begin
                repeat (150) @(negedge clk);
                bus2.adc_reading_valid = 1'b1;
                @(negedge clk);
                bus2.adc_reading_valid = 1'b0;
            end
        end
    end

    initial begin
        fork
            begin : main_seq
                int e0, s0, r;
                reset = 1'b1;
                enable = 1'b0;
                bus.param_write_valid   = 1'b0;
                bus.param_write_address = 1'b0;
                bus.param_write_value   = '0;
                repeat (3) @(negedge clk);
                chk("rst_adc_start", 32'(bus.adc_start), 32'd0);
                chk("rst_sensor", 32'(bus.sensor_reading), 32'd0);
                chk("rst_p", 32'(bus.p), 32'd0);
                chk("rst_setpoint", 32'(bus.setpoint), 32'd0);
                chk("rst_update", 32'(bus.update), 32'd0);
                chk("rst_motor_enable", 32'(bus.motor_enable), 32'd0);
                chk("rst_fault", 32'(bus.fault), 32'd0);
                chk("rst_overrun", 32'(bus.overrun_count), 32'd0);
                reset = 1'b0;
                @(negedge clk);

                enable = 1'b1;
                e0 = cyc + 1;
                for (int i = 0; i < 5; i++) begin
                    exp_start(e0 + 100 * i);
                    exp_update(e0 + 100 * i + 12, 12'hABC,
                               (i >= 3) ? 8'h40 : 8'h00, (i >= 4) ? 8'h80 : 8'h00);
                end
                wait_cyc(e0 + 5);
                chk("motor_enable_before_sample", 32'(bus.motor_enable), 32'd0);
                wait_cyc(e0 + 250);
                write_param(ADDR_P, 8'h40);
                wait_cyc(e0 + 311);
                write_param(ADDR_SETPOINT, 8'h80);

                exp_start(e0 + 500);
                wait_cyc(e0 + 502);
                adc_value = 12'h123;
                wait_cyc(e0 + 505);
                chk("motor_enable_running", 32'(bus.motor_enable), 32'd1);
                enable = 1'b0;
                @(negedge clk);
                chk("motor_enable_after_drop", 32'(bus.motor_enable), 32'd0);
                wait_cyc(e0 + 515);
                chk("sensor_held_after_drop", 32'(bus.sensor_reading), 32'hABC);
                wait_cyc(e0 + 520);
                enable = 1'b1;
                s0 = cyc + 1;
                exp_start(s0);
                exp_update(s0 + 12, 12'h123, 8'h40, 8'h80);

                // timeout, timeout, valid, then three timeouts into FAULT
                wait_cyc(s0 + 20);
                adc_plan.push_back(-1);
                adc_plan.push_back(-1);
                adc_plan.push_back(10);
                adc_plan.push_back(-1);
                adc_plan.push_back(-1);
                adc_plan.push_back(-1);
                for (int k = 1; k <= 6; k++) begin
                    exp_start(s0 + 100 * k);
                    if (k == 3) exp_update(s0 + 312, 12'h123, 8'h40, 8'h80);
                end
                wait_cyc(s0 + 230);
                chk("fault_after_two_timeouts", 32'(bus.fault), 32'd0);
                wait_cyc(s0 + 530);
                chk("fault_after_cleared_count", 32'(bus.fault), 32'd0);
                wait_cyc(s0 + 619);
                chk("fault_before_third", 32'(bus.fault), 32'd0);
                wait_cyc(s0 + 622);
                chk("fault_latched", 32'(bus.fault), 32'd1);
                chk("motor_enable_in_fault", 32'(bus.motor_enable), 32'd0);
                chk("overrun_none", 32'(bus.overrun_count), 32'd0);

                wait_cyc(s0 + 650);
                enable = 1'b0;
                wait_cyc(s0 + 660);
                enable = 1'b1;
                wait_cyc(s0 + 670);
                write_param(ADDR_P, 8'h11);
                wait_cyc(s0 + 900);
                chk("fault_sticky", 32'(bus.fault), 32'd1);
                chk("p_frozen_in_fault", 32'(bus.p), 32'h40);

                reset = 1'b1;
                repeat (2) @(negedge clk);
                chk("reset_clears_fault", 32'(bus.fault), 32'd0);
                chk("reset_clears_p", 32'(bus.p), 32'd0);
                chk("reset_clears_setpoint", 32'(bus.setpoint), 32'd0);
                reset = 1'b0;
                r = cyc + 1;
                exp_start(r);
                exp_update(r + 12, 12'h123, 8'h00, 8'h00);
                wait_cyc(r + 20);
                enable = 1'b0;
                wait_cyc(r + 60);
                chk("pending_events", 32'(exp_q.size()), 32'd0);
            end
            begin : ovr_seq
                int s2;
                int pts[8];
                reset2 = 1'b1;
                enable2 = 1'b0;
                bus2.param_write_valid   = 1'b0;
                bus2.param_write_address = 1'b0;
                bus2.param_write_value   = '0;
                pts = '{0, 1, 2, 127, 253, 254, 255, 259};
                repeat (3) @(negedge clk);
                reset2 = 1'b0;
                @(negedge clk);
                enable2 = 1'b1;
                s2 = cyc + 1;
                wait_cyc(s2 + 50);
                chk("ovr_initial", 32'(bus2.overrun_count), 32'd0);
                foreach (pts[j]) begin
                    wait_cyc(s2 + 200 * pts[j] + 150);
                    chk("ovr_count", 32'(bus2.overrun_count),
                        (pts[j] + 1 > 255) ? 32'd255 : 32'(pts[j] + 1));
                end
                chk("ovr_sensor", 32'(bus2.sensor_reading), 32'h5A5);
                chk("ovr_no_fault", 32'(bus2.fault), 32'd0);
            end
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
